cmc_psum_accum: RTL
===================

# cmc_psum_accum

Temporal partial-sum accumulator directly downstream of the 4-to-1 CMC adder tree. It consumes one 18-bit signed tree sum per accepted beat and accumulates beats into a group delimited by `in_last`. It then presents the saturated group total, with its beat count, on a single-entry valid/ready output register. This register feeds the CMC writeback stage.

## Interface
Parameters:
- `IN_W`, 18: width of signed input sum; matches adder-tree output.
- `ACC_W`, 24: signed accumulator and output width; must be > `IN_W`.
- `CNT_W`, 8: beat-counter width.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_sum`  in  `IN_W`  signed tree sum.
- `in_last`  in  1  beat closes the current group.
- `out_valid`  out  1  group result held.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  `ACC_W`  signed saturated group total.
- `out_count`  out  `CNT_W`  beats in group; saturates at all-ones.
- `out_sat`  out  1  accumulator clamped at least once in this group.

## Operation
- Beat accepted when `in_valid && in_ready`. Output taken when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`. A new group can start in the same cycle the previous result drains.
- FSM states:
  - IDLE: no open group.
  - ACCUM: group open, result not yet produced.
  - HOLD: `out_valid` = 1.
  - A result can be held in HOLD while a new group is open. Track this with a separate `grp_open` bit rather than an extra state, or with equivalent encoding.
- Beat in IDLE, or first beat after a close:
  - acc ← sign-extend(`in_sum`).
  - cnt ← 1.
  - sat ← 0.
- Subsequent beat:
  - acc ← clamp(acc + sign-extend(`in_sum`)). Compute the sum at `ACC_W`+1 bits, then clamp to [−2^(`ACC_W`−1), 2^(`ACC_W`−1)−1].
  - sat ← sat | clamped.
  - cnt ← min(cnt+1, 2^`CNT_W`−1).
- Beat with `in_last`:
  - The next-state acc/cnt/sat (including this beat) load into `out_data`/`out_count`/`out_sat`.
  - `out_valid` ← 1.
  - The group closes.
- A single-beat group (`in_last` on the first beat) is legal. Result = sign-extended input, count 1.
- Simultaneous output handshake and accepted last beat: the new result replaces the old one, and `out_valid` stays 1.
- Output handshake with no new last beat: `out_valid` ← 0. `out_data`/`out_count`/`out_sat` hold their last values.
- No beat is dropped or double-counted under any `in_valid`/`out_ready` pattern.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_count` = 0, `out_sat` = 0.
  - Accumulator and counter = 0, FSM in IDLE.
  - `in_ready` = 1 (follows from `out_valid` = 0).
- Latency: last beat accepted in cycle N → `out_valid` high with its result in cycle N+1.
- Throughput: one beat per cycle sustained while `out_ready` = 1. Back-to-back single-beat groups produce one result per cycle.
- `out_valid`/`out_data` are registered. `in_ready` is the only combinational output.
- Output data is stable while `out_valid && !out_ready`.
- Reset asserted mid-group or in HOLD: the partial group and any held result are discarded immediately. Post-reset, the first beat starts a fresh group.

## Structure
- Shared package `cmc_pkg`:
  - `CMC_SUM_W` = 18 and `CMC_ACC_W` = 24 constants.
  - FSM state enum.
  - `cmc_psum_t` struct {data, count, sat}.
- One natural sub-module: `cmc_sat_add`, a combinational signed add with clamp and an overflow flag, parameterised by width.
- Everything else is in one module.

## Test plan
- Single-beat groups: beats 5 (last), −7 (last), `out_ready` = 1 → results 5 then −7 on consecutive cycles, count 1 each, sat 0, no bubbles.
- Four-beat group: 100, −30, 131071, −131072 (last on 4th) → `out_data` = 69, `out_count` = 4, `out_valid` one cycle after 4th beat.
- Backpressure: `out_ready` = 0 with result 69 held; offer a new group → `in_ready` = 0, no beat accepted, data stable. Raise `out_ready` in the same cycle as the new beat 9 (last) → `out_valid` stays 1, next result 9.
- Saturation: 65 beats of +131071, last on 65th → `out_data` = 8388607, `out_sat` = 1, `out_count` = 65. Next group of 1 → `out_sat` = 0.
- Count saturation: `CNT_W` = 2, five beats of 1 → `out_count` = 3, `out_data` = 5.
- Reset mid-group: two beats of 50, assert `rst_n` low, release, one beat 7 (last) → `out_data` = 7, count 1. All outputs 0 during reset.

Source files
------------

// File: rtl/cmc_pkg.sv
// Shared constants, FSM encoding and result record for the CMC partial-sum datapath.
package cmc_pkg;

  localparam int CMC_SUM_W = 18;
  localparam int CMC_ACC_W = 24;
  localparam int CMC_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } cmc_state_e;

  typedef struct packed {
    logic signed [CMC_ACC_W-1:0] data;
    logic [CMC_CNT_W-1:0]        count;
    logic                        sat;
  } cmc_psum_t;

endpackage

// File: rtl/cmc_sat_add.sv
// Combinational signed adder that clamps to the W-bit range and flags when it did.
module cmc_sat_add #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] wide_s;

  assign wide_s = {a[W-1], a} + {b[W-1], b};

  // Disagreeing top two bits mean the true sum left the W-bit range.
  always_comb begin
    ovf = (wide_s[W] != wide_s[W-1]);
    if (ovf) begin
      sum = wide_s[W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = wide_s[W-1:0];
    end
  end

endmodule

// File: rtl/cmc_psum_accum.sv
// Accumulates adder-tree sums into in_last-delimited groups and presents the
// saturated total and beat count on a single-entry valid/ready register.
module cmc_psum_accum
  import cmc_pkg::*;
#(
  parameter int IN_W  = CMC_SUM_W,
  parameter int ACC_W = CMC_ACC_W,
  parameter int CNT_W = CMC_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_sum,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cmc_state_e              state_r, state_nxt_s;
  logic                    grp_open_r, grp_open_nxt_s;
  logic signed [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic                    sat_r, sat_nxt_s;
  logic signed [ACC_W-1:0] sum_ext_s, add_s;
  logic                    add_ovf_s;
  logic                    beat_s, take_s, close_s, hold_s;

  assign in_ready  = !out_valid || out_ready;
  assign beat_s    = in_valid && in_ready;
  assign take_s    = out_valid && out_ready;
  assign close_s   = beat_s && in_last;
  assign hold_s    = (state_r == ST_HOLD);
  assign sum_ext_s = {{(ACC_W-IN_W){in_sum[IN_W-1]}}, in_sum};

  cmc_sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_r),
    .b   (sum_ext_s),
    .sum (add_s),
    .ovf (add_ovf_s)
  );

  // Group datapath: restart on the first beat after a close, otherwise clamp-accumulate.
  always_comb begin
    acc_nxt_s      = acc_r;
    cnt_nxt_s      = cnt_r;
    sat_nxt_s      = sat_r;
    grp_open_nxt_s = grp_open_r;
    if (beat_s) begin
      if (!grp_open_r) begin
        acc_nxt_s = sum_ext_s;
        cnt_nxt_s = CNT_ONE;
        sat_nxt_s = 1'b0;
      end else begin
        acc_nxt_s = add_s;
        cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        sat_nxt_s = sat_r | add_ovf_s;
      end
      grp_open_nxt_s = !in_last;
    end else begin
      grp_open_nxt_s = grp_open_r;
    end
  end

  // HOLD dominates; a group may be open underneath it, tracked by grp_open.
  always_comb begin
    state_nxt_s = state_r;
    if (close_s) begin
      state_nxt_s = ST_HOLD;
    end else if (hold_s && !take_s) begin
      state_nxt_s = ST_HOLD;
    end else if (grp_open_nxt_s) begin
      state_nxt_s = ST_ACCUM;
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // Control and accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      grp_open_r <= 1'b0;
      acc_r      <= '0;
      cnt_r      <= '0;
      sat_r      <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      grp_open_r <= grp_open_nxt_s;
      acc_r      <= acc_nxt_s;
      cnt_r      <= cnt_nxt_s;
      sat_r      <= sat_nxt_s;
      out_valid  <= (state_nxt_s == ST_HOLD);
    end
  end

  // Result register loads only on a closing beat, so it holds through stalls and drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (close_s) begin
      out_data  <= acc_nxt_s;
      out_count <= cnt_nxt_s;
      out_sat   <= sat_nxt_s;
    end else begin
      out_data  <= out_data;
      out_count <= out_count;
      out_sat   <= out_sat;
    end
  end

endmodule
